// File: rtl/ch_sched_pkg.sv
// rtl/ch_sched_pkg.sv - shared state encoding and default sizing for the channel scheduler
package ch_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLR   = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;
  localparam state_t ST_DONE  = 3'd5;
  localparam state_t ST_ABORT = 3'd6;

  localparam int CLR_CYC_DEF = 2;
  localparam int TMO_W_DEF   = 16;

endpackage

// File: rtl/ch_sched_rr_arb.sv
// rtl/ch_sched_rr_arb.sv - combinational round-robin pick, search starts just after last_grant
module rr_arb #(
  parameter int NCH = 4,
  parameter int LW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [LW-1:0]  last_grant,
  output logic [NCH-1:0] gnt,
  output logic [LW-1:0]  gnt_idx,
  output logic           vld
);

  logic [LW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = LW'((int'(last_grant) + k) % NCH);
      if (!vld && req[cand]) begin
        vld     = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = vld;
  end

endmodule

// File: rtl/ch_sched.sv
// rtl/ch_sched.sv - shares one compression engine among NCH channel buffers, one job at a time
module ch_sched
  import ch_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CLR_CYC = CLR_CYC_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_reset,
  output logic [NCH-1:0]    ch_endn,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  input  logic [NCH*64-1:0] ch_src,
  input  logic [NCH-1:0]    ch_src_last,
  input  logic [NCH-1:0]    ch_src_empty,
  input  logic [NCH-1:0]    ch_src_almost_empty,
  output logic [NCH-1:0]    ch_src_getn,
  output logic [63:0]       ch_dst,
  output logic              ch_dst_last,
  output logic [NCH-1:0]    ch_dst_putn,
  input  logic [NCH-1:0]    ch_dst_full,
  input  logic [NCH-1:0]    ch_dst_almost_full,
  output logic              e_start,
  input  logic              e_done,
  output logic [63:0]       e_src,
  output logic              e_src_last,
  output logic              e_src_empty,
  output logic              e_src_almost_empty,
  input  logic              e_src_getn,
  input  logic [63:0]       e_dst,
  input  logic              e_dst_last,
  input  logic              e_dst_putn,
  output logic              e_dst_full,
  output logic              e_dst_almost_full,
  output logic [NCH-1:0]    grant,
  output logic              busy
);

  localparam int LW = $clog2(NCH);
  localparam int CW = $clog2(CLR_CYC) + 1;

  state_t         state;
  logic [LW-1:0]  cur;
  logic [LW-1:0]  last_grant;
  logic [CW-1:0]  clr_cnt;
  logic [TMO_W-1:0] wdog;
  logic           rst_hold;

  logic [NCH-1:0] pick;
  logic [LW-1:0]  pick_idx;
  logic           pick_vld;
  logic           run;
  logic [63:0]    src_word [NCH];

  rr_arb #(.NCH(NCH)) u_rr_arb (
    .req       (ch_req),
    .last_grant(last_grant),
    .gnt       (pick),
    .gnt_idx   (pick_idx),
    .vld       (pick_vld)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state      <= ST_IDLE;
      grant      <= '0;
      cur        <= '0;
      last_grant <= LW'(NCH - 1);
      clr_cnt    <= '0;
      wdog       <= '0;
      rst_hold   <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant   <= pick;
            cur     <= pick_idx;
            clr_cnt <= '0;
            state   <= ST_CLR;
          end
        end
        ST_CLR: begin
          if (clr_cnt == CW'(CLR_CYC - 1)) state <= ST_START;
          else                             clr_cnt <= clr_cnt + 1'b1;
        end
        ST_START: begin
          wdog  <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          // e_done takes priority over a watchdog expiring in the same cycle
          if (e_done)                          state <= ST_DRAIN;
          else if (&wdog)                      state <= ST_ABORT;
          else if (!e_src_getn || !e_dst_putn) wdog  <= '0;
          else                                 wdog  <= wdog + 1'b1;
        end
        ST_DRAIN: begin
          if (ch_ack[cur]) state <= ST_DONE;
        end
        ST_DONE, ST_ABORT: begin
          grant      <= '0;
          last_grant <= cur;
          state      <= ST_IDLE;
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_src
    assign src_word[i] = ch_src[64*i +: 64];
  end

  assign run  = (state == ST_RUN);
  assign busy = (state != ST_IDLE);

  // rst_hold keeps every channel cleared from async reset until the first clock edge
  assign ch_reset = {NCH{rst_hold}} | (((state == ST_CLR) || (state == ST_ABORT)) ? grant : '0);
  assign ch_endn  = ~((state == ST_DRAIN) ? grant : '0);
  assign ch_done  = (state == ST_DONE)  ? grant : '0;
  assign ch_err   = (state == ST_ABORT) ? grant : '0;
  assign e_start  = (state == ST_START);

  assign e_src              = run ? src_word[cur] : '0;
  assign e_src_last         = run & ch_src_last[cur];
  assign e_src_empty        = ~run | ch_src_empty[cur];
  assign e_src_almost_empty = ~run | ch_src_almost_empty[cur];
  assign e_dst_full         = ~run | ch_dst_full[cur];
  assign e_dst_almost_full  = ~run | ch_dst_almost_full[cur];

  assign ch_src_getn = ~(grant & {NCH{run & ~e_src_getn}});
  assign ch_dst_putn = ~(grant & {NCH{run & ~e_dst_putn}});
  assign ch_dst      = e_dst;
  assign ch_dst_last = e_dst_last;

endmodule

// File: tb/tb_ch_sched.sv
// tb/tb_ch_sched.sv - randomized self-checking bench for ch_sched
module tb_ch_sched;

  localparam int NCH = 4;
  localparam int CLR = 2;
  localparam int TW  = 6;
  localparam int TMO = 1 << TW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ch_req, ch_ack, ch_reset, ch_endn, ch_done, ch_err;
  logic [NCH*64-1:0] ch_src;
  logic [NCH-1:0]    ch_src_last, ch_src_empty, ch_src_almost_empty, ch_src_getn;
  logic [63:0]       ch_dst;
  logic              ch_dst_last;
  logic [NCH-1:0]    ch_dst_putn, ch_dst_full, ch_dst_almost_full;
  logic              e_start, e_done;
  logic [63:0]       e_src;
  logic              e_src_last, e_src_empty, e_src_almost_empty, e_src_getn;
  logic [63:0]       e_dst;
  logic              e_dst_last, e_dst_putn, e_dst_full, e_dst_almost_full;
  logic [NCH-1:0]    grant;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int m_last;

  always #5 clk = ~clk;

  ch_sched #(.NCH(NCH), .CLR_CYC(CLR), .TMO_W(TW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .ch_req(ch_req), .ch_ack(ch_ack), .ch_reset(ch_reset), .ch_endn(ch_endn),
    .ch_done(ch_done), .ch_err(ch_err),
    .ch_src(ch_src), .ch_src_last(ch_src_last), .ch_src_empty(ch_src_empty),
    .ch_src_almost_empty(ch_src_almost_empty), .ch_src_getn(ch_src_getn),
    .ch_dst(ch_dst), .ch_dst_last(ch_dst_last), .ch_dst_putn(ch_dst_putn),
    .ch_dst_full(ch_dst_full), .ch_dst_almost_full(ch_dst_almost_full),
    .e_start(e_start), .e_done(e_done),
    .e_src(e_src), .e_src_last(e_src_last), .e_src_empty(e_src_empty),
    .e_src_almost_empty(e_src_almost_empty), .e_src_getn(e_src_getn),
    .e_dst(e_dst), .e_dst_last(e_dst_last), .e_dst_putn(e_dst_putn),
    .e_dst_full(e_dst_full), .e_dst_almost_full(e_dst_almost_full),
    .grant(grant), .busy(busy)
  );

  // Requester closest after the previous owner, counting forward modulo NCH.
  function automatic int rr_next(input logic [NCH-1:0] r, input int last);
    int best, bd;
    best = -1;
    bd   = NCH;
    for (int i = 0; i < NCH; i++)
      if (r[i] && ((i - last - 1 + 2*NCH) % NCH) < bd) begin
        bd   = (i - last - 1 + 2*NCH) % NCH;
        best = i;
      end
    return best;
  endfunction

  function automatic logic [NCH-1:0] onehot(input int g);
    logic [NCH-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int g);
    logic [NCH-1:0] oh;
    oh = onehot(g);
    tick;
    checks++;
    if (grant !== oh) $display("FAIL grant: got %b want %b", grant, oh);
    if (grant !== oh) errors++;
    for (int c = 0; c < CLR; c++) begin
      checks++;
      if (ch_reset !== oh || e_start !== 1'b0) begin
        errors++;
        $display("FAIL clr_phase[%0d]: ch_reset=%b e_start=%b want %b/0", c, ch_reset, e_start, oh);
      end
      tick;
    end
    checks++;
    if (e_start !== 1'b1 || ch_reset !== '0) begin
      errors++;
      $display("FAIL start_pulse: e_start=%b ch_reset=%b want 1/0", e_start, ch_reset);
    end
    tick;
    checks++;
    if (e_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: e_start=%b busy=%b want 0/1", e_start, busy);
    end
  endtask

  task automatic traffic(input int g, input int ns, input int nd);
    logic [NCH-1:0] oh;
    logic [68:0] exp_t, got_t;
    int s, d;
    bit rs, wd;
    oh = onehot(g);
    s = 0;
    d = 0;
    while (s < ns || d < nd) begin
      for (int i = 0; i < NCH; i++) ch_src[i*64 +: 64] = {$urandom, $urandom};
      ch_src_last         = NCH'($urandom);
      ch_src_empty        = NCH'($urandom);
      ch_src_almost_empty = NCH'($urandom);
      ch_dst_full         = NCH'($urandom);
      ch_dst_almost_full  = NCH'($urandom);
      e_dst      = {$urandom, $urandom};
      e_dst_last = 1'($urandom);
      rs = (s < ns) && ($urandom_range(0, 2) != 0);
      wd = (d < nd) && ($urandom_range(0, 2) != 0);
      e_src_getn = !rs;
      e_dst_putn = !wd;
      #1;
      exp_t = {ch_src[g*64 +: 64], ch_src_last[g], ch_src_empty[g], ch_src_almost_empty[g],
               ch_dst_full[g], ch_dst_almost_full[g]};
      got_t = {e_src, e_src_last, e_src_empty, e_src_almost_empty, e_dst_full, e_dst_almost_full};
      checks++;
      if (got_t !== exp_t) begin
        errors++;
        $display("FAIL src_mux ch%0d: got %h want %h", g, got_t, exp_t);
      end
      checks++;
      if (ch_src_getn !== (rs ? ~oh : '1) || ch_dst_putn !== (wd ? ~oh : '1) ||
          ch_dst !== e_dst || ch_dst_last !== e_dst_last) begin
        errors++;
        $display("FAIL strobe_route ch%0d: getn=%b putn=%b rs=%0d wd=%0d", g, ch_src_getn, ch_dst_putn, rs, wd);
      end
      if (rs) s++;
      if (wd) d++;
      tick;
    end
    e_src_getn = 1'b1;
    e_dst_putn = 1'b1;
  endtask

  task automatic finish_job(input int g, input bit ack_early);
    logic [NCH-1:0] oh;
    oh = onehot(g);
    e_done = 1'b1;
    if (ack_early) ch_ack = oh;
    tick;
    e_done = 1'b0;
    ch_ack = '0;
    checks++;
    if (ch_endn !== ~oh || ch_done !== '0 || ch_err !== '0) begin
      errors++;
      $display("FAIL drain_entry ch%0d: endn=%b done=%b err=%b", g, ch_endn, ch_done, ch_err);
    end
    e_src_getn   = 1'b0;
    e_dst_putn   = 1'b0;
    ch_src_empty = '0;
    ch_dst_full  = '0;
    ch_ack       = ~oh;
    #1;
    checks++;
    if ({ch_src_getn, ch_dst_putn, e_src_empty, e_src_almost_empty, e_dst_full, e_dst_almost_full} !== '1) begin
      errors++;
      $display("FAIL idle_mux ch%0d: getn=%b putn=%b empty=%b full=%b", g, ch_src_getn, ch_dst_putn, e_src_empty, e_dst_full);
    end
    tick;
    ch_ack     = '0;
    e_src_getn = 1'b1;
    e_dst_putn = 1'b1;
    checks++;
    if (ch_endn !== ~oh || ch_done !== '0) begin
      errors++;
      $display("FAIL foreign_ack ch%0d: endn=%b done=%b", g, ch_endn, ch_done);
    end
    ch_ack = oh;
    tick;
    ch_ack = '0;
    checks++;
    if (ch_done !== oh || grant !== oh || ch_err !== '0) begin
      errors++;
      $display("FAIL done_pulse ch%0d: done=%b grant=%b err=%b", g, ch_done, grant, ch_err);
    end
    tick;
    checks++;
    if (ch_done !== '0 || grant !== '0 || busy !== 1'b0 || ch_endn !== '1) begin
      errors++;
      $display("FAIL back_idle ch%0d: done=%b grant=%b busy=%b endn=%b", g, ch_done, grant, busy, ch_endn);
    end
    m_last = g;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if (ch_reset !== '1 || grant !== '0 || busy !== 1'b0 || ch_endn !== '1 || ch_done !== '0 ||
        ch_err !== '0 || e_start !== 1'b0 || e_src_empty !== 1'b1 || e_dst_full !== 1'b1 ||
        ch_src_getn !== '1 || ch_dst_putn !== '1) begin
      errors++;
      $display("FAIL reset_state: reset=%b grant=%b busy=%b endn=%b", ch_reset, grant, busy, ch_endn);
    end
    rst_n  = 1'b1;
    m_last = NCH - 1;
    tick;
    checks++;
    if (ch_reset !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: reset=%b busy=%b want 0/0", ch_reset, busy);
    end
  endtask

  task automatic test_single;
    ch_req = 4'b0100;
    start_job(rr_next(ch_req, m_last));
    ch_req = '0;
    traffic(2, 8, 3);
    finish_job(2, 1'b1);
  endtask

  task automatic test_round_robin;
    int g;
    rst_n = 1'b0;
    tick;
    rst_n  = 1'b1;
    m_last = NCH - 1;
    ch_req = '1;
    for (int j = 0; j < 5; j++) begin
      g = rr_next(ch_req, m_last);
      start_job(g);
      traffic(g, $urandom_range(1, 6), $urandom_range(1, 4));
      finish_job(g, 1'($urandom));
    end
    ch_req = '0;
  endtask

  task automatic test_random;
    int g;
    for (int j = 0; j < 6; j++) begin
      ch_req = NCH'($urandom_range(1, (1 << NCH) - 1));
      g = rr_next(ch_req, m_last);
      start_job(g);
      ch_req = NCH'($urandom);
      traffic(g, $urandom_range(0, 5), $urandom_range(1, 5));
      finish_job(g, 1'($urandom));
    end
    ch_req = '0;
  endtask

  task automatic test_stall;
    int g, n;
    logic [NCH-1:0] oh;
    ch_req = 4'b1010;
    g  = rr_next(ch_req, m_last);
    oh = onehot(g);
    start_job(g);
    n = 0;
    while (ch_err === '0 && n < TMO + 8) begin
      tick;
      n++;
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL stall_timeout: abort after %0d run cycles want %0d", n, TMO);
    end
    checks++;
    if (ch_err !== oh || ch_reset !== oh || ch_done !== '0) begin
      errors++;
      $display("FAIL abort_pulse: err=%b reset=%b done=%b want %b/%b/0", ch_err, ch_reset, ch_done, oh, oh);
    end
    tick;
    checks++;
    if (ch_err !== '0 || grant !== '0 || ch_done !== '0) begin
      errors++;
      $display("FAIL after_abort: err=%b grant=%b done=%b", ch_err, grant, ch_done);
    end
    m_last = g;
    g = rr_next(ch_req, m_last);
    start_job(g);
    ch_req = '0;
    traffic(g, 2, 2);
    finish_job(g, 1'b0);
  endtask

  task automatic test_expiry_edone;
    ch_req = 4'b1000;
    start_job(rr_next(ch_req, m_last));
    ch_req = '0;
    repeat (TMO - 1) tick;
    finish_job(3, 1'b0);
  endtask

  task automatic test_isolation;
    logic exp_full;
    ch_req = 4'b0001;
    start_job(rr_next(ch_req, m_last));
    ch_req             = '0;
    ch_src_empty       = 4'b1110;
    ch_dst_full        = 4'b0010;
    ch_dst_almost_full = '0;
    #1;
    checks++;
    if (e_src_empty !== 1'b0 || e_dst_full !== 1'b0) begin
      errors++;
      $display("FAIL iso_status: e_src_empty=%b e_dst_full=%b want 0/0", e_src_empty, e_dst_full);
    end
    for (int i = 0; i < 6; i++) begin
      e_dst_putn     = 1'(i % 2);
      exp_full       = (i >= 3);
      ch_dst_full[0] = exp_full;
      #1;
      checks++;
      if (ch_dst_putn !== (e_dst_putn ? 4'hF : 4'hE) || e_dst_full !== exp_full) begin
        errors++;
        $display("FAIL iso_toggle[%0d]: putn=%b e_dst_full=%b want %b/%b", i, ch_dst_putn, e_dst_full, (e_dst_putn ? 4'hF : 4'hE), exp_full);
      end
      tick;
    end
    e_dst_putn = 1'b1;
    finish_job(0, 1'b0);
  endtask

  task automatic test_mid_reset;
    ch_req = 4'b0010;
    start_job(rr_next(ch_req, m_last));
    traffic(1, 3, 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ch_reset !== '1 || grant !== '0 || busy !== 1'b0 || ch_endn !== '1 || e_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: reset=%b grant=%b busy=%b endn=%b", ch_reset, grant, busy, ch_endn);
    end
    tick;
    tick;
    checks++;
    if (ch_done !== '0 || ch_err !== '0 || ch_reset !== '1) begin
      errors++;
      $display("FAIL reset_hold: done=%b err=%b reset=%b", ch_done, ch_err, ch_reset);
    end
    rst_n  = 1'b1;
    m_last = NCH - 1;
    start_job(rr_next(ch_req, m_last));
    ch_req = '0;
    traffic(1, 4, 2);
    finish_job(1, 1'b0);
  endtask

  initial begin
    ch_req = '0;  ch_ack = '0;  ch_src = '0;
    ch_src_last = '0;  ch_src_empty = '1;  ch_src_almost_empty = '1;
    ch_dst_full = '0;  ch_dst_almost_full = '0;
    e_done = 1'b0;  e_src_getn = 1'b1;  e_dst = '0;  e_dst_last = 1'b0;  e_dst_putn = 1'b1;
    rst_n = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_random;
    test_stall;
    test_expiry_edone;
    test_isolation;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
